// File: rtl/ifu_fetch_pkg.sv
// ----------------------------------------------------------------------------
// ifu_fetch_pkg
//   Shared definitions for the instruction fetch stage: default widths,
//   control-bus and trap-bus bit positions, the NOP encoding, FSM state and
//   next-PC select encodings, plus a helper that builds a one-hot trap word.
//
//   Optional build macro used by ifu_fetch: IFU_RESP_BYPASS_EN.
// ----------------------------------------------------------------------------
package ifu_fetch_pkg;

    // Datapath widths (the fetch top re-exposes these as parameters).
    localparam int unsigned XLEN_DEF     = 64;
    localparam int unsigned INST_LEN_DEF = 32;
    localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;

    // Pipeline control buses: one bit per pipeline register boundary.
    localparam int unsigned CTRLBUS_LEN   = 6;
    localparam int unsigned CTRLBUS_IF_ID = 1;

    // Trap bus: one bit per exception cause raised in the front end.
    localparam int unsigned TRAP_LEN                   = 8;
    localparam int unsigned TRAP_INST_MISALIGNED_IDX   = 0;
    localparam int unsigned TRAP_INST_ACCESS_FAULT_IDX = 1;

    // addi x0, x0, 0
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IFU_ST_REQ  = 2'd0,  // presenting a request for pc
        IFU_ST_WAIT = 2'd1,  // request accepted, awaiting its response
        IFU_ST_HOLD = 2'd2,  // instruction buffered and offered to IF/ID
        IFU_ST_KILL = 2'd3   // outstanding response must be swallowed
    } ifu_state_e;

    typedef enum logic [1:0] {
        PC_SEL_HOLD = 2'd0,
        PC_SEL_INC  = 2'd1,
        PC_SEL_LOAD = 2'd2
    } pc_sel_e;

    function automatic logic [TRAP_LEN-1:0] trap_bit(input int unsigned idx);
        trap_bit      = '0;
        trap_bit[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/ifu_pc_gen.sv
// ----------------------------------------------------------------------------
// ifu_pc_gen
//   Program counter of the fetch stage: a three-way next-PC mux (hold,
//   sequential +4, load) feeding an asynchronously reset PC register.
//   The +4 increment wraps modulo 2^XLEN.
//
// Ports
//   clk      in   clock
//   rst      in   asynchronous reset, active low
//   sel      in   next-PC select (hold / +4 / load)
//   load_pc  in   PC taken when sel = PC_SEL_LOAD
//   pc       out  current PC
// ----------------------------------------------------------------------------
module ifu_pc_gen
    import ifu_fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            rst,
    input  pc_sel_e         sel,
    input  logic [XLEN-1:0] load_pc,
    output logic [XLEN-1:0] pc
);

    logic [XLEN-1:0] pc_nxt;

    // NOTE: every combinational output gets a value on every path (here via
    // the default arm) so no latch is inferred.
    always_comb begin
        unique case (sel)
            PC_SEL_INC:  pc_nxt = pc + XLEN'(4);
            PC_SEL_LOAD: pc_nxt = load_pc;
            default:     pc_nxt = pc;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_nxt;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// ----------------------------------------------------------------------------
// ifu_fetch
//   Instruction fetch stage. Owns the PC, issues one request at a time on an
//   SRAM-like instruction bus and presents {address, instruction, trap bits}
//   to the IF/ID pipeline register. A redirect or an IF/ID flush ("kill")
//   discards whatever is in flight and restarts fetch at the new PC; a
//   response belonging to a killed request is swallowed in the KILL state.
//
//   Optional build macro IFU_RESP_BYPASS_EN: when defined, a response that
//   arrives while IF/ID can consume is forwarded combinationally to the
//   outputs and fetch proceeds without visiting HOLD (bus-to-IF/ID
//   combinational path). When undefined, every instruction is registered in
//   the hold buffer first.
//
// Ports
//   clk                in   clock
//   rst                in   asynchronous reset, active low
//   stall_valid_i      in   pipeline stall bus; IF/ID bit holds the stage
//   flush_valid_i      in   pipeline flush bus; IF/ID bit kills fetch
//   redirect_valid_i   in   load redirect_pc_i this cycle
//   redirect_pc_i      in   redirect target
//   if_req_valid_o     out  bus request valid
//   if_req_addr_o      out  bus request address
//   if_req_ready_i     in   bus accepts the request
//   if_resp_valid_i    in   bus response valid (one per accepted request)
//   if_resp_data_i     in   fetched instruction word
//   if_resp_err_i      in   access fault on this response
//   inst_addr_if_o     out  instruction address to IF/ID
//   inst_data_if_o     out  instruction word to IF/ID
//   trap_bus_if_o      out  trap bits to IF/ID
//   if_stall_req_o     out  no instruction available this cycle
// ----------------------------------------------------------------------------
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEF,
    parameter int unsigned     INST_LEN = INST_LEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CTRLBUS_LEN-1:0] stall_valid_i,
    input  logic [CTRLBUS_LEN-1:0] flush_valid_i,
    input  logic                   redirect_valid_i,
    input  logic [XLEN-1:0]        redirect_pc_i,
    output logic                   if_req_valid_o,
    output logic [XLEN-1:0]        if_req_addr_o,
    input  logic                   if_req_ready_i,
    input  logic                   if_resp_valid_i,
    input  logic [INST_LEN-1:0]    if_resp_data_i,
    input  logic                   if_resp_err_i,
    output logic [XLEN-1:0]        inst_addr_if_o,
    output logic [INST_LEN-1:0]    inst_data_if_o,
    output logic [TRAP_LEN-1:0]    trap_bus_if_o,
    output logic                   if_stall_req_o
);

    localparam logic [INST_LEN-1:0] NOP = INST_LEN'(INST_NOP);

    ifu_state_e state;
    ifu_state_e state_nxt;
    pc_sel_e    pc_sel;

    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     kill_pc;
    logic                consume;
    logic                kill;
    logic                aligned;
    logic                handshake;
    logic                bypass;
    logic [INST_LEN-1:0] resp_inst;
    logic [TRAP_LEN-1:0] resp_trap;

    logic                hold_load;
    logic [INST_LEN-1:0] hold_load_data;
    logic [TRAP_LEN-1:0] hold_load_trap;
    logic [XLEN-1:0]     hold_addr;
    logic [INST_LEN-1:0] hold_data;
    logic [TRAP_LEN-1:0] hold_trap;

    // Only the IF/ID bits of the control buses concern this stage.
    logic ctrl_unused;
    assign ctrl_unused = ^{stall_valid_i, flush_valid_i};

    assign consume = !stall_valid_i[CTRLBUS_IF_ID];
    assign kill    = redirect_valid_i | flush_valid_i[CTRLBUS_IF_ID];
    // A flush without a redirect refetches the current PC.
    assign kill_pc = redirect_valid_i ? redirect_pc_i : pc;
    assign aligned = (pc[1:0] == 2'b00);

    // The request is gated by reset directly so nothing is issued while rst
    // is held low, yet the first cycle after release already requests.
    assign if_req_valid_o = rst && (state == IFU_ST_REQ) && aligned;
    assign if_req_addr_o  = pc;
    assign handshake      = if_req_valid_o & if_req_ready_i;

    // A faulting response is replaced by a NOP carrying the fault bit.
    assign resp_inst = if_resp_err_i ? NOP : if_resp_data_i;
    assign resp_trap = if_resp_err_i ? trap_bit(TRAP_INST_ACCESS_FAULT_IDX) : '0;

`ifdef IFU_RESP_BYPASS_EN
    assign bypass = (state == IFU_ST_WAIT) && if_resp_valid_i && consume && !kill;
`else
    assign bypass = 1'b0;
`endif

    ifu_pc_gen #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk     (clk),
        .rst     (rst),
        .sel     (pc_sel),
        .load_pc (kill_pc),
        .pc      (pc)
    );

    // ------------------------------------------------------------------
    // Next-state logic. Kill overrides every normal transition; the PC is
    // reloaded on any kill so the redirect target is never lost.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        pc_sel         = PC_SEL_HOLD;
        hold_load      = 1'b0;
        hold_load_data = resp_inst;
        hold_load_trap = resp_trap;

        if (kill) begin
            pc_sel = PC_SEL_LOAD;
            unique case (state)
                IFU_ST_REQ:  state_nxt = handshake ? IFU_ST_KILL : IFU_ST_REQ;
                // A response landing in the kill cycle is simply dropped.
                IFU_ST_WAIT: state_nxt = if_resp_valid_i ? IFU_ST_REQ : IFU_ST_KILL;
                IFU_ST_HOLD: state_nxt = IFU_ST_REQ;
                // The single outstanding response must still be absorbed,
                // otherwise KILL would wait for a response that never comes.
                IFU_ST_KILL: state_nxt = if_resp_valid_i ? IFU_ST_REQ : IFU_ST_KILL;
                default:     state_nxt = IFU_ST_REQ;
            endcase
        end else begin
            unique case (state)
                IFU_ST_REQ: begin
                    if (!aligned) begin
                        hold_load      = 1'b1;
                        hold_load_data = NOP;
                        hold_load_trap = trap_bit(TRAP_INST_MISALIGNED_IDX);
                        state_nxt      = IFU_ST_HOLD;
                    end else if (handshake) begin
                        state_nxt = IFU_ST_WAIT;
                    end
                end
                IFU_ST_WAIT: begin
                    if (if_resp_valid_i) begin
                        if (bypass) begin
                            pc_sel    = PC_SEL_INC;
                            state_nxt = IFU_ST_REQ;
                        end else begin
                            hold_load = 1'b1;
                            state_nxt = IFU_ST_HOLD;
                        end
                    end
                end
                IFU_ST_HOLD: begin
                    if (consume) begin
                        pc_sel    = PC_SEL_INC;
                        state_nxt = IFU_ST_REQ;
                    end
                end
                IFU_ST_KILL: begin
                    if (if_resp_valid_i) begin
                        state_nxt = IFU_ST_REQ;
                    end
                end
                default: state_nxt = IFU_ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IFU_ST_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the hold buffer is a plain register, so it is reset to the idle
    // triple; nothing is ever exposed from it outside HOLD anyway.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_addr <= '0;
            hold_data <= NOP;
            hold_trap <= '0;
        end else if (hold_load) begin
            hold_addr <= pc;
            hold_data <= hold_load_data;
            hold_trap <= hold_load_trap;
        end
    end

    // ------------------------------------------------------------------
    // IF/ID-facing outputs: the buffer in HOLD, the live response when
    // bypassing, otherwise an idle NOP with a stall request.
    // ------------------------------------------------------------------
    always_comb begin
        inst_addr_if_o = '0;
        inst_data_if_o = NOP;
        trap_bus_if_o  = '0;
        if_stall_req_o = 1'b1;
        if (state == IFU_ST_HOLD) begin
            inst_addr_if_o = hold_addr;
            inst_data_if_o = hold_data;
            trap_bus_if_o  = hold_trap;
            if_stall_req_o = 1'b0;
        end else if (bypass) begin
            inst_addr_if_o = pc;
            inst_data_if_o = resp_inst;
            trap_bus_if_o  = resp_trap;
            if_stall_req_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// ----------------------------------------------------------------------------
// tb_ifu_fetch
//   Self-checking bench for ifu_fetch. A transaction-level reference model
//   (pc, "request outstanding", "outstanding response is stale", "instruction
//   offered") predicts every output each cycle; directed scenarios pin the
//   model with literal expectations, then a randomized phase stresses
//   stalls, flushes, redirects, bus back-pressure, errors and resets.
// ----------------------------------------------------------------------------
module tb_ifu_fetch;
    import ifu_fetch_pkg::*;

`ifdef IFU_RESP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int unsigned IFID  = CTRLBUS_IF_ID;
    localparam logic [31:0] NOP32 = 32'h0000_0013;
    localparam logic [TRAP_LEN-1:0] T_MIS = trap_bit(TRAP_INST_MISALIGNED_IDX);
    localparam logic [TRAP_LEN-1:0] T_AF  = trap_bit(TRAP_INST_ACCESS_FAULT_IDX);

    logic                   clk = 1'b0;
    logic                   rst;
    logic [CTRLBUS_LEN-1:0] stall_valid_i;
    logic [CTRLBUS_LEN-1:0] flush_valid_i;
    logic                   redirect_valid_i;
    logic [63:0]            redirect_pc_i;
    logic                   if_req_valid_o;
    logic [63:0]            if_req_addr_o;
    logic                   if_req_ready_i;
    logic                   if_resp_valid_i;
    logic [31:0]            if_resp_data_i;
    logic                   if_resp_err_i;
    logic [63:0]            inst_addr_if_o;
    logic [31:0]            inst_data_if_o;
    logic [TRAP_LEN-1:0]    trap_bus_if_o;
    logic                   if_stall_req_o;

    ifu_fetch dut (
        .clk              (clk),
        .rst              (rst),
        .stall_valid_i    (stall_valid_i),
        .flush_valid_i    (flush_valid_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .if_req_valid_o   (if_req_valid_o),
        .if_req_addr_o    (if_req_addr_o),
        .if_req_ready_i   (if_req_ready_i),
        .if_resp_valid_i  (if_resp_valid_i),
        .if_resp_data_i   (if_resp_data_i),
        .if_resp_err_i    (if_resp_err_i),
        .inst_addr_if_o   (inst_addr_if_o),
        .inst_data_if_o   (inst_data_if_o),
        .trap_bus_if_o    (trap_bus_if_o),
        .if_stall_req_o   (if_stall_req_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model state ----------------
    logic [63:0]         m_pc;
    bit                  m_pending;  // a request was accepted, response not yet seen
    bit                  m_discard;  // that response belongs to a killed fetch
    bit                  m_have;     // an instruction is being offered to IF/ID
    logic [63:0]         m_baddr;
    logic [31:0]         m_bdata;
    logic [TRAP_LEN-1:0] m_btrap;

    // ---------------- bus model state / configuration ----------------
    bit          bus_out;
    int          bus_cnt;
    logic [31:0] bus_data;
    bit          bus_err;
    int          bus_accepts = 0;
    bit          ready_always;
    int          fix_delay;
    bit          use_fix_data;
    logic [31:0] fix_data;
    bit          fix_err;
    bit          rand_err;
    bit          inject_stale;
    logic [31:0] stale_data;

    // ---------------- per-cycle snapshot of DUT outputs ----------------
    logic                s_valid;
    logic [63:0]         s_req_addr;
    logic [63:0]         s_addr;
    logic [31:0]         s_data;
    logic [TRAP_LEN-1:0] s_trap;
    logic                s_stall;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_ne(input string name, input logic [63:0] act, input logic [63:0] bad);
        n_cmp++;
        if (act === bad) begin
            n_bad++;
            $display("FAIL %s: got %h which must not appear at %0t", name, act, $time);
        end
    endtask

    task automatic model_reset();
        m_pc      = 64'h0000_0000_8000_0000;
        m_pending = 1'b0;
        m_discard = 1'b0;
        m_have    = 1'b0;
        m_baddr   = '0;
        m_bdata   = NOP32;
        m_btrap   = '0;
    endtask

    // One clock cycle: drive bus signals, compare against the model, advance
    // model and bus, then return just after the rising edge.
    task automatic step();
        bit                  kill, consume, hs, e_valid, e_stall;
        logic [63:0]         e_addr, npc;
        logic [31:0]         e_data;
        logic [TRAP_LEN-1:0] e_trap;

        @(negedge clk);
        if_resp_valid_i = (bus_out && bus_cnt == 0) || inject_stale;
        if_resp_data_i  = inject_stale ? stale_data : bus_data;
        if_resp_err_i   = inject_stale ? 1'b0 : bus_err;
        if_req_ready_i  = ready_always ? 1'b1 : ($urandom_range(0, 3) != 0);
        #1;
        s_valid    = if_req_valid_o;
        s_req_addr = if_req_addr_o;
        s_addr     = inst_addr_if_o;
        s_data     = inst_data_if_o;
        s_trap     = trap_bus_if_o;
        s_stall    = if_stall_req_o;

        if (!rst) model_reset();

        kill    = redirect_valid_i || flush_valid_i[IFID];
        consume = !stall_valid_i[IFID];
        e_valid = rst && !m_pending && !m_have && (m_pc[1:0] == 2'b00);
        e_addr  = '0;
        e_data  = NOP32;
        e_trap  = '0;
        e_stall = 1'b1;
        if (m_have) begin
            e_addr  = m_baddr;
            e_data  = m_bdata;
            e_trap  = m_btrap;
            e_stall = 1'b0;
        end else if (BYP && rst && m_pending && !m_discard && if_resp_valid_i && consume && !kill) begin
            e_addr  = m_pc;
            e_data  = if_resp_err_i ? NOP32 : if_resp_data_i;
            e_trap  = if_resp_err_i ? T_AF : '0;
            e_stall = 1'b0;
        end

        check("cyc_req_valid", 64'(s_valid), 64'(e_valid));
        if (e_valid) check("cyc_req_addr", s_req_addr, m_pc);
        check("cyc_inst_addr", s_addr, e_addr);
        check("cyc_inst_data", 64'(s_data), 64'(e_data));
        check("cyc_trap", 64'(s_trap), 64'(e_trap));
        check("cyc_stall_req", 64'(s_stall), 64'(e_stall));

        if (rst) begin
            hs  = e_valid && if_req_ready_i;
            npc = redirect_valid_i ? redirect_pc_i : m_pc;
            if (kill) begin
                m_pc   = npc;
                m_have = 1'b0;
                if (m_pending) begin
                    if (if_resp_valid_i) begin
                        m_pending = 1'b0;
                        m_discard = 1'b0;
                    end else begin
                        m_discard = 1'b1;
                    end
                end else if (hs) begin
                    m_pending = 1'b1;
                    m_discard = 1'b1;
                end
            end else if (m_have) begin
                if (consume) begin
                    m_have = 1'b0;
                    m_pc   = m_pc + 64'd4;
                end
            end else if (m_pending) begin
                if (if_resp_valid_i) begin
                    m_pending = 1'b0;
                    if (m_discard) begin
                        m_discard = 1'b0;
                    end else if (BYP && consume) begin
                        m_pc = m_pc + 64'd4;
                    end else begin
                        m_have  = 1'b1;
                        m_baddr = m_pc;
                        m_bdata = if_resp_err_i ? NOP32 : if_resp_data_i;
                        m_btrap = if_resp_err_i ? T_AF : '0;
                    end
                end
            end else if (m_pc[1:0] != 2'b00) begin
                m_have  = 1'b1;
                m_baddr = m_pc;
                m_bdata = NOP32;
                m_btrap = T_MIS;
            end else if (hs) begin
                m_pending = 1'b1;
                m_discard = 1'b0;
            end
        end

        // Bus model reacts to what the DUT actually did.
        if (!rst) begin
            bus_out = 1'b0;
        end else begin
            if (bus_out && bus_cnt == 0) bus_out = 1'b0;
            else if (bus_out) bus_cnt--;
            if (s_valid && if_req_ready_i) begin
                bus_out  = 1'b1;
                bus_accepts++;
                bus_cnt  = (fix_delay >= 0) ? fix_delay : int'($urandom_range(0, 3));
                bus_data = use_fix_data ? fix_data : 32'($urandom);
                bus_err  = rand_err ? ($urandom_range(0, 15) == 0) : fix_err;
            end
        end
        inject_stale = 1'b0;

        @(posedge clk);
        #1;
    endtask

    task automatic wait_inst(input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (s_stall && n < 20);
        check({name, "_inst_timeout"}, 64'(s_stall), 64'd0);
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!s_valid && n < 20);
        check({name, "_req_timeout"}, 64'(s_valid), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] acc0;

        rst              = 1'b0;
        stall_valid_i    = '0;
        flush_valid_i    = '0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = '0;
        if_req_ready_i   = 1'b0;
        if_resp_valid_i  = 1'b0;
        if_resp_data_i   = '0;
        if_resp_err_i    = 1'b0;
        bus_out          = 1'b0;
        bus_cnt          = 0;
        bus_data         = '0;
        bus_err          = 1'b0;
        ready_always     = 1'b1;
        fix_delay        = 0;
        use_fix_data     = 1'b1;
        fix_data         = 32'h0000_0013;
        fix_err          = 1'b0;
        rand_err         = 1'b0;
        inject_stale     = 1'b0;
        stale_data       = '0;
        model_reset();

        // Reset state.
        step();
        step();
        check("rst_req_valid", 64'(s_valid), 64'd0);
        check("rst_stall_req", 64'(s_stall), 64'd1);
        check("rst_inst_addr", s_addr, 64'd0);
        check("rst_inst_data", 64'(s_data), 64'h13);
        check("rst_trap", 64'(s_trap), 64'd0);

        // First fetch after reset release.
        rst = 1'b1;
        step();
        check("t1_req_valid", 64'(s_valid), 64'd1);
        check("t1_req_addr", s_req_addr, 64'h8000_0000);
        wait_inst("t1");
        check("t1_inst_addr", s_addr, 64'h8000_0000);
        check("t1_inst_data", 64'(s_data), 64'h13);
        check("t1_trap", 64'(s_trap), 64'd0);
        fix_data = 32'h0010_0093;
        wait_req("t1_next");
        check("t1_next_addr", s_req_addr, 64'h8000_0004);

        // Stall in HOLD for five cycles.
        stall_valid_i[IFID] = 1'b1;
        wait_inst("t2");
        check("t2_inst_addr", s_addr, 64'h8000_0004);
        check("t2_inst_data", 64'(s_data), 64'h0010_0093);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_hold_addr", s_addr, 64'h8000_0004);
            check("t2_hold_data", 64'(s_data), 64'h0010_0093);
            check("t2_hold_trap", 64'(s_trap), 64'd0);
            check("t2_hold_no_req", 64'(s_valid), 64'd0);
            check("t2_hold_stall_req", 64'(s_stall), 64'd0);
        end
        stall_valid_i[IFID] = 1'b0;
        fix_data  = 32'hDEAD_BEEF;
        fix_delay = 3;
        wait_req("t2_next");
        check("t2_next_addr", s_req_addr, 64'h8000_0008);

        // Redirect while waiting; the late response must be discarded.
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'h8000_1000;
        step();
        redirect_valid_i = 1'b0;
        check("t3_kill_stall_req", 64'(s_stall), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_ne("t3_no_stale_data", 64'(s_data), 64'hDEAD_BEEF);
            check("t3_kill_no_req", 64'(s_valid), 64'd0);
        end
        fix_delay = 0;
        fix_data  = 32'h0000_0013;
        wait_req("t3_next");
        check("t3_next_addr", s_req_addr, 64'h8000_1000);

        // Misaligned redirect: no bus request, misaligned trap offered.
        stall_valid_i[IFID] = 1'b1;
        wait_inst("t4_pre");
        acc0 = 64'(bus_accepts);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'h8000_0002;
        step();
        redirect_valid_i = 1'b0;
        wait_inst("t4");
        check("t4_inst_addr", s_addr, 64'h8000_0002);
        check("t4_inst_data", 64'(s_data), 64'h13);
        check("t4_trap", 64'(s_trap), 64'(T_MIS));
        check("t4_no_bus_req", 64'(bus_accepts), acc0);

        // Access fault at 0x80000008.
        fix_err          = 1'b1;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'h8000_0008;
        step();
        redirect_valid_i = 1'b0;
        wait_inst("t5");
        fix_err = 1'b0;
        check("t5_inst_addr", s_addr, 64'h8000_0008);
        check("t5_inst_data", 64'(s_data), 64'h13);
        check("t5_trap", 64'(s_trap), 64'(T_AF));

        // Reset while waiting; a stale response right after release is ignored.
        stall_valid_i[IFID] = 1'b0;
        fix_delay = 3;
        wait_req("t6_pre");
        step();
        rst = 1'b0;
        step();
        step();
        rst          = 1'b1;
        fix_delay    = 0;
        fix_data     = 32'h0000_0013;
        inject_stale = 1'b1;
        stale_data   = 32'hBAD0_C0DE;
        step();
        check("t6_req_valid", 64'(s_valid), 64'd1);
        check("t6_req_addr", s_req_addr, 64'h8000_0000);
        check("t6_stall_req", 64'(s_stall), 64'd1);
        wait_inst("t6");
        check("t6_inst_addr", s_addr, 64'h8000_0000);
        check("t6_inst_data", 64'(s_data), 64'h13);

        // PC wrap at the top of the address space.
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        redirect_valid_i = 1'b0;
        wait_inst("wrap_pre");
        check("wrap_inst_addr", s_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        wait_req("wrap");
        check("wrap_req_addr", s_req_addr, 64'd0);

        // Randomized phase.
        ready_always = 1'b0;
        fix_delay    = -1;
        use_fix_data = 1'b0;
        rand_err     = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            stall_valid_i       = CTRLBUS_LEN'($urandom);
            stall_valid_i[IFID] = ($urandom_range(0, 3) == 0);
            flush_valid_i       = CTRLBUS_LEN'($urandom);
            flush_valid_i[IFID] = ($urandom_range(0, 19) == 0);
            redirect_valid_i    = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 15))
                0:       redirect_pc_i = 64'h8000_0000 + 64'({$urandom_range(0, 255), 2'b10});
                1:       redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFF8;
                default: redirect_pc_i = 64'h8000_0000 + 64'({$urandom_range(0, 255), 2'b00});
            endcase
            rst = ($urandom_range(0, 599) != 0);
            step();
        end
        rst = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
